jtkcpu_stkseq: RTL and testbench

// Parametrised stack push/pull sequencer for the jtkcpu core. Given a register mask and stack pointer,
// it issues one byte bus cycle per cen to push registers onto or pull them from the U/S stack.

---
 rtl/jtkcpu_stkseq.sv | 106 ++++++++++
 tb/tb_jtkcpu_stkseq.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtkcpu_stkseq.sv
// jtkcpu_stkseq: issues one stack byte cycle per cen to push or pull a masked register set
module jtkcpu_stkseq #(
  parameter int NREG = 8,
  parameter int AW = 16,
  parameter logic [NREG-1:0] WMASK = 'hF0,
  localparam int SW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  input  logic            start,
  input  logic            pull,
  input  logic [NREG-1:0] mask,
  input  logic [AW-1:0]   sp_in,
  input  logic [7:0]      psh_din,
  input  logic [7:0]      din,
  output logic            busy,
  output logic            done,
  output logic [AW-1:0]   addr,
  output logic            we,
  output logic [7:0]      dout,
  output logic [SW-1:0]   sel,
  output logic            hi,
  output logic            pul_we,
  output logic [SW-1:0]   pul_sel,
  output logic            pul_hi,
  output logic [7:0]      pul_data,
  output logic [AW-1:0]   sp_out
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t st, st_n;
  logic [NREG-1:0] rem, src_m, rem_n;
  logic [SW-1:0] lo_idx, hi_idx, idx, bsel;
  logic [AW-1:0] sp, src_sp;
  logic idle, ph, src_ph, src_pull, pull_r, wide, last, byte_hi, go, act, issue, rd, bhi;
  // In IDLE the byte about to be issued comes straight from the inputs, so sel/hi
  // can steer psh_din before the start edge registers dout.
  assign idle = st == IDLE;
  assign src_m = idle ? mask : rem;
  assign src_ph = idle ? 1'b0 : ph;
  assign src_pull = idle ? pull : pull_r;
  assign src_sp = idle ? sp_in : sp;
  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    for (int i = 0; i < NREG; i++) if (src_m[i]) hi_idx = SW'(i);
    for (int i = NREG - 1; i >= 0; i--) if (src_m[i]) lo_idx = SW'(i);
  end
  assign idx = src_pull ? lo_idx : hi_idx;
  assign wide = WMASK[idx];
  // Push sends low then high; pull takes high then low.
  assign byte_hi = src_pull ? wide & ~src_ph : src_ph;
  assign last = ~wide | src_ph;
  assign rem_n = last ? src_m & ~(NREG'(1) << idx) : src_m;
  assign go = idle ? start : st == RUN;
  assign act = go & |src_m;
  assign issue = cen & act;
  assign sel = act & ~src_pull ? idx : '0;
  assign hi = act & ~src_pull & byte_hi;
  assign busy = st == RUN;
  assign done = st == DONE;
  assign sp_out = sp;
  always_comb begin
    st_n = st;
    if (cen) st_n = idle ? (start ? RUN : IDLE) : st == RUN ? (|rem ? RUN : DONE) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= IDLE;
    else st <= st_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      we <= 1'b0;
      rd <= 1'b0;
      pul_we <= 1'b0;
      pul_data <= '0;
      pul_sel <= '0;
      pul_hi <= 1'b0;
      pull_r <= 1'b0;
      rem <= '0;
      ph <= 1'b0;
      sp <= '0;
      addr <= '0;
      dout <= '0;
      bsel <= '0;
      bhi <= 1'b0;
    end else if (cen) begin
      we <= issue & ~src_pull;
      rd <= issue & src_pull;
      pul_we <= rd;
      if (rd) begin
        pul_data <= din;
        pul_sel <= bsel;
        pul_hi <= bhi;
      end
      if (idle & start) pull_r <= pull;
      if (issue) begin
        rem <= rem_n;
        ph <= ~last;
        sp <= src_pull ? src_sp + AW'(1) : src_sp - AW'(1);
        addr <= src_pull ? src_sp : src_sp - AW'(1);
        bsel <= idx;
        bhi <= byte_hi;
        if (!src_pull) dout <= psh_din;
      end else if (idle & start) sp <= sp_in;
    end
endmodule

// File: tb/tb_jtkcpu_stkseq.sv
// tb_jtkcpu_stkseq: directed and randomized push/pull sequences against a byte-list stack model
module tb_jtkcpu_stkseq;
  localparam logic [7:0] WM = 8'hF0;
  logic clk = 0, rst = 1, cen = 0, start = 0, pull = 0;
  logic [7:0] mask = 0;
  logic [15:0] sp_in = 0;
  logic [7:0] psh_din, din, dout, pul_data;
  logic busy, done, we, hi, pul_we, pul_hi;
  logic [15:0] addr, sp_out;
  logic [2:0] sel, pul_sel;
  logic [15:0] regv [8];
  logic [7:0] mem [65536];
  bit wrn [65536];
  logic [23:0] wq[$], ew[$];
  logic [11:0] pq[$], ep[$];
  logic [15:0] esp;
  int vecs = 0, errs = 0;

  jtkcpu_stkseq dut (
    .clk(clk), .rst(rst), .cen(cen), .start(start), .pull(pull), .mask(mask), .sp_in(sp_in),
    .psh_din(psh_din), .din(din), .busy(busy), .done(done), .addr(addr), .we(we), .dout(dout),
    .sel(sel), .hi(hi), .pul_we(pul_we), .pul_sel(pul_sel), .pul_hi(pul_hi), .pul_data(pul_data),
    .sp_out(sp_out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rd_mem(input logic [15:0] a);
    return wrn[a] ? mem[a] : a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  assign din = rd_mem(addr);
  assign psh_din = hi ? regv[sel][15:8] : regv[sel][7:0];

  always @(posedge clk)
    if (cen && !rst) begin
      if (we) begin
        mem[addr] <= dout;
        wrn[addr] <= 1'b1;
        wq.push_back({addr, dout});
      end
      if (pul_we) pq.push_back({pul_sel, pul_hi, pul_data});
    end

  task automatic model(input bit p, input logic [7:0] m, input logic [15:0] s);
    logic [15:0] a;
    a = s;
    ew.delete();
    ep.delete();
    if (!p) begin
      for (int i = 7; i >= 0; i--)
        if (m[i]) begin
          a = a - 16'd1;
          ew.push_back({a, regv[i][7:0]});
          if (WM[i]) begin
            a = a - 16'd1;
            ew.push_back({a, regv[i][15:8]});
          end
        end
    end else begin
      for (int i = 0; i < 8; i++)
        if (m[i]) begin
          if (WM[i]) begin
            ep.push_back({3'(i), 1'b1, rd_mem(a)});
            a = a + 16'd1;
          end
          ep.push_back({3'(i), 1'b0, rd_mem(a)});
          a = a + 16'd1;
        end
    end
    esp = a;
  endtask

  task automatic run(input bit p, input logic [7:0] m, input logic [15:0] s, input bit gaps,
                     output int edges, output logic [15:0] so, output logic b0, output logic after);
    wq.delete();
    pq.delete();
    edges = 0;
    @(negedge clk);
    cen = 1; pull = p; mask = m; sp_in = s; start = 1;
    @(negedge clk);
    start = 0; pull = 1'($urandom); mask = 8'($urandom); sp_in = 16'($urandom);
    b0 = busy;
    for (int t = 0; t < 400 && !done; t++) begin
      cen = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      if (cen) edges++;
      @(negedge clk);
    end
    vecs++;
    if (!done) begin
      errs++;
      $display("FAIL run_timeout: done=%b busy=%b, required done=1", done, busy);
    end
    so = sp_out;
    cen = 1;
    @(negedge clk);
    after = done;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    vecs++;
    if ({busy, done, we, pul_we, hi, sel, addr, dout, sp_out} !== '0) begin
      errs++;
      $display("FAIL reset_outputs: busy=%b done=%b we=%b pul_we=%b addr=%h sp_out=%h, required all 0",
               busy, done, we, pul_we, addr, sp_out);
    end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_push_basic(input bit gaps);
    logic [23:0] exp_w [3];
    int e;
    logic [15:0] so;
    logic b0, af;
    exp_w = '{24'h1FFFEF, 24'h1FFEBE, 24'h1FFD5A};
    regv[7] = 16'hBEEF;
    regv[0] = 16'h005A;
    run(0, 8'h81, 16'h2000, gaps, e, so, b0, af);
    vecs++;
    if (e !== 3 || so !== 16'h1FFD || b0 !== 1'b1 || af !== 1'b0) begin
      errs++;
      $display("FAIL push_basic_ctl gaps=%0d: edges=%0d sp_out=%h busy0=%b done_after=%b, required 3 1ffd 1 0",
               gaps, e, so, b0, af);
    end
    vecs++;
    if (wq.size() != 3) begin
      errs++;
      $display("FAIL push_basic_count gaps=%0d: %0d writes, required 3", gaps, wq.size());
    end else
      for (int i = 0; i < 3; i++) begin
        vecs++;
        if (wq[i] !== exp_w[i]) begin
          errs++;
          $display("FAIL push_basic_byte%0d gaps=%0d: %h, required %h", i, gaps, wq[i], exp_w[i]);
        end
      end
  endtask

  task automatic test_pull_basic;
    logic [11:0] exp_p [3];
    int e;
    logic [15:0] so;
    logic b0, af;
    exp_p = '{12'h05A, 12'hFBE, 12'hEEF};
    run(1, 8'h81, 16'h1FFD, 0, e, so, b0, af);
    vecs++;
    if (e !== 3 || so !== 16'h2000 || wq.size() != 0 || pq.size() != 3) begin
      errs++;
      $display("FAIL pull_basic_ctl: edges=%0d sp_out=%h writes=%0d pulls=%0d, required 3 2000 0 3",
               e, so, wq.size(), pq.size());
    end else
      for (int i = 0; i < 3; i++) begin
        vecs++;
        if (pq[i] !== exp_p[i]) begin
          errs++;
          $display("FAIL pull_basic_byte%0d: %h, required %h", i, pq[i], exp_p[i]);
        end
      end
  endtask

  task automatic test_empty;
    int e;
    logic [15:0] s, so;
    logic b0, af;
    for (int p = 0; p < 2; p++) begin
      s = 16'($urandom);
      run(1'(p), 8'h00, s, 0, e, so, b0, af);
      vecs++;
      if (e !== 1 || so !== s || wq.size() + pq.size() != 0 || af !== 1'b0) begin
        errs++;
        $display("FAIL empty_mask pull=%0d: edges=%0d sp_out=%h bytes=%0d done_after=%b, required 1 %h 0 0",
                 p, e, so, wq.size() + pq.size(), af, s);
      end
    end
  endtask

  task automatic test_wrap;
    int e;
    logic [15:0] so, r;
    logic b0, af;
    r = 16'($urandom);
    regv[7] = r;
    run(0, 8'h80, 16'h0001, 0, e, so, b0, af);
    vecs++;
    if (so !== 16'hFFFF || wq.size() != 2 || wq[0] !== {16'h0000, r[7:0]} || wq[1] !== {16'hFFFF, r[15:8]}) begin
      errs++;
      $display("FAIL push_wrap: sp_out=%h writes=%0d first=%h, required ffff 2 %h", so, wq.size(),
               wq.size() > 0 ? wq[0] : 24'hx, {16'h0000, r[7:0]});
    end
    run(1, 8'h80, 16'hFFFF, 0, e, so, b0, af);
    vecs++;
    if (so !== 16'h0001 || pq.size() != 2 || pq[0] !== {4'hF, r[15:8]} || pq[1] !== {4'hE, r[7:0]}) begin
      errs++;
      $display("FAIL pull_wrap: sp_out=%h pulls=%0d first=%h, required 0001 2 %h", so, pq.size(),
               pq.size() > 0 ? pq[0] : 12'hx, {4'hF, r[15:8]});
    end
  endtask

  task automatic test_ignore;
    int t;
    @(negedge clk);
    cen = 0; start = 1; mask = 8'hFF; pull = 0; sp_in = 16'h4000;
    @(negedge clk);
    vecs++;
    if (busy !== 1'b0 || we !== 1'b0) begin
      errs++;
      $display("FAIL start_no_cen: busy=%b we=%b, required 0 0", busy, we);
    end
    wq.delete();
    cen = 1; mask = 8'h81; sp_in = 16'h3000;
    @(negedge clk);
    start = 1; mask = 8'hFF; pull = 1; sp_in = 16'h0100;
    repeat (2) @(negedge clk);
    start = 0;
    for (t = 0; t < 50 && !done; t++) @(negedge clk);
    vecs++;
    if (!done || wq.size() != 3 || sp_out !== 16'h2FFD) begin
      errs++;
      $display("FAIL start_while_busy: done=%b writes=%0d sp_out=%h, required 1 3 2ffd", done, wq.size(), sp_out);
    end
    start = 1;
    @(negedge clk);
    start = 0;
    vecs++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL start_while_done: busy=%b done=%b, required 0 0", busy, done);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int e;
    logic [15:0] s, so;
    logic b0, af;
    for (int i = 0; i < 8; i++) regv[i] = 16'($urandom);
    s = 16'($urandom);
    wq.delete();
    @(negedge clk);
    cen = 1; start = 1; pull = 0; mask = 8'hFF; sp_in = s;
    @(negedge clk);
    start = 0;
    for (int t = 0; t < 50 && wq.size() < 4; t++) @(negedge clk);
    vecs++;
    if (we !== 1'b1 || busy !== 1'b1) begin
      errs++;
      $display("FAIL reset_mid_pre: we=%b busy=%b, required 1 1", we, busy);
    end
    #2 rst = 1;
    #1;
    vecs++;
    if (we !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_mid_async: we=%b busy=%b, required 0 0", we, busy);
    end
    repeat (2) @(negedge clk);
    rst = 0;
    model(0, 8'hFF, s);
    run(0, 8'hFF, s, 0, e, so, b0, af);
    vecs++;
    if (e !== 12 || so !== esp || wq.size() != 12) begin
      errs++;
      $display("FAIL reset_mid_rerun: edges=%0d sp_out=%h writes=%0d, required 12 %h 12", e, so, wq.size(), esp);
    end else
      for (int i = 0; i < 12; i++) begin
        vecs++;
        if (wq[i] !== ew[i]) begin
          errs++;
          $display("FAIL reset_mid_byte%0d: %h, required %h", i, wq[i], ew[i]);
        end
      end
  endtask

  task automatic test_random;
    int e, n;
    bit p;
    logic [7:0] m;
    logic [15:0] s, so;
    logic b0, af;
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < 8; i++) regv[i] = 16'($urandom);
      p = 1'($urandom);
      m = 8'($urandom);
      s = (it % 5 == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      model(p, m, s);
      n = ew.size() + ep.size();
      run(p, m, s, 1'($urandom), e, so, b0, af);
      vecs++;
      if (e !== (n == 0 ? 1 : n) || so !== esp || af !== 1'b0) begin
        errs++;
        $display("FAIL rand%0d_ctl: edges=%0d sp_out=%h done_after=%b, required %0d %h 0", it, e, so, af,
                 n == 0 ? 1 : n, esp);
      end
      vecs++;
      if (wq.size() != ew.size() || pq.size() != ep.size()) begin
        errs++;
        $display("FAIL rand%0d_count: writes=%0d pulls=%0d, required %0d %0d", it, wq.size(), pq.size(),
                 ew.size(), ep.size());
      end else begin
        for (int i = 0; i < ew.size(); i++) begin
          vecs++;
          if (wq[i] !== ew[i]) begin
            errs++;
            $display("FAIL rand%0d_wr%0d: %h, required %h", it, i, wq[i], ew[i]);
          end
        end
        for (int i = 0; i < ep.size(); i++) begin
          vecs++;
          if (pq[i] !== ep[i]) begin
            errs++;
            $display("FAIL rand%0d_rd%0d: %h, required %h", it, i, pq[i], ep[i]);
          end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) regv[i] = 16'h0;
    test_reset;
    test_push_basic(0);
    test_pull_basic;
    test_empty;
    test_wrap;
    test_push_basic(1);
    test_ignore;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
